// File: rtl/tdc_pkg.sv
// Shared types for the TDC hit controller.
// Holds the controller state encoding and the fine-code width helper.
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLD,
        S_DEAD,
        S_REARM
    } state_t;

    function automatic int fine_w(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/tdc_thermo_count.sv
// Bubble-tolerant thermometer decode.
// Counts every set tap, so isolated bubbles do not shift the result.
module tdc_thermo_count
    import tdc_pkg::*;
#(
    parameter int NUM    = 12,
    parameter int FINE_W = fine_w(NUM)
) (
    input  logic [NUM-1:0]    taps,
    output logic [FINE_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM; i++) begin
            count = count + FINE_W'(taps[i]);
        end
    end

endmodule

// File: rtl/tdc_hit_controller.sv
// TDC hit capture controller: timestamps the first edge of a hit,
// holds it for a valid/ready consumer, then enforces a dead time.
module tdc_hit_controller
    import tdc_pkg::*;
#(
    parameter int NUM         = 12,
    parameter int COARSE_W    = 16,
    parameter int DEAD_CYCLES = 4,
    localparam int FINE_W     = fine_w(NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM-1:0]      taps,
    input  logic                ts_ready,
    output logic                ts_valid,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic [7:0]          miss_cnt,
    output logic                busy
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    state_t              state;
    state_t              state_nx;
    logic [NUM-1:0]      taps_prev;
    logic [COARSE_W-1:0] coarse;
    logic [DW-1:0]       dead_cnt;
    logic [FINE_W-1:0]   fine;
    logic                hit;
    logic                capture;
    logic                miss;
    logic                dead_done;

    tdc_thermo_count #(
        .NUM    (NUM),
        .FINE_W (FINE_W)
    ) u_count (
        .taps  (taps),
        .count (fine)
    );

    assign hit       = (taps_prev == '0) && (taps != '0);
    assign dead_done = (dead_cnt == DW'(DEAD_CYCLES - 1));

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        miss     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nx = S_ARMED;
            end
            S_ARMED: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                end else if (hit) begin
                    state_nx = S_HOLD;
                    capture  = 1'b1;
                end
            end
            // a disabled controller still completes the pending handshake
            S_HOLD: begin
                miss = hit;
                if (ts_ready) state_nx = enable ? S_DEAD : S_IDLE;
            end
            S_DEAD: begin
                miss = hit;
                if (!enable)        state_nx = S_IDLE;
                else if (dead_done) state_nx = S_REARM;
            end
            S_REARM: begin
                miss = hit;
                if (!enable)          state_nx = S_IDLE;
                else if (taps == '0)  state_nx = S_ARMED;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            taps_prev <= '0;
            coarse    <= '0;
            dead_cnt  <= '0;
            ts_coarse <= '0;
            ts_fine   <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_nx;
            taps_prev <= taps;
            if (state == S_IDLE)  coarse <= '0;
            else if (enable)      coarse <= coarse + COARSE_W'(1);
            if (state != S_DEAD)  dead_cnt <= '0;
            else if (!dead_done)  dead_cnt <= dead_cnt + DW'(1);
            if (capture) begin
                ts_coarse <= coarse;
                ts_fine   <= fine;
            end
            if (miss && (miss_cnt != 8'hFF)) miss_cnt <= miss_cnt + 8'd1;
        end
    end

    assign ts_valid = (state == S_HOLD);
    assign busy     = (state == S_HOLD) || (state == S_DEAD) ||
                      (state == S_REARM);

endmodule

// File: tb/tb_tdc_hit_controller.sv
// Scoreboard bench for tdc_hit_controller: a 16-bit and a 4-bit coarse
// instance share stimulus and are checked against one behavioural model.
module tb_tdc_hit_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        ts_ready = 1'b0;
    logic [11:0] taps = '0;

    logic        v16, v4, b16, b4;
    logic [15:0] c16;
    logic [3:0]  c4;
    logic [3:0]  f16, f4;
    logic [7:0]  m16, m4;

    always #5 clk = ~clk;

    tdc_hit_controller #(.NUM(12), .COARSE_W(16), .DEAD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .taps(taps),
        .ts_ready(ts_ready), .ts_valid(v16), .ts_coarse(c16),
        .ts_fine(f16), .miss_cnt(m16), .busy(b16)
    );

    tdc_hit_controller #(.NUM(12), .COARSE_W(4), .DEAD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .taps(taps),
        .ts_ready(ts_ready), .ts_valid(v4), .ts_coarse(c4),
        .ts_fine(f4), .miss_cnt(m4), .busy(b4)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: activity flags and a dead-time countdown.
    bit          on = 0;
    bit          holding = 0;
    bit          waiting = 0;
    int          dead_left = 0;
    int          miss = 0;
    int          coarse = 0;
    logic [11:0] prev = '0;
    int          qc[$];
    int          qf[$];

    always @(posedge clk or negedge rst) begin
        bit hit;
        int cap;
        if (!rst) begin
            on = 0; holding = 0; waiting = 0; dead_left = 0;
            miss = 0; coarse = 0; prev = '0;
            qc.delete(); qf.delete();
        end else begin
            hit = (prev == 0) && (taps != 0);
            cap = coarse;
            if (!on) begin
                coarse = 0;
                on = enable;
            end else begin
                if (enable) coarse = (coarse + 1) % 65536;
                if (holding) begin
                    if (hit && miss < 255) miss++;
                    if (ts_ready) begin
                        holding = 0;
                        if (enable) dead_left = 4;
                        else on = 0;
                    end
                end else if (dead_left > 0) begin
                    if (hit && miss < 255) miss++;
                    if (!enable) begin
                        on = 0; dead_left = 0;
                    end else begin
                        dead_left--;
                        if (dead_left == 0) waiting = 1;
                    end
                end else if (waiting) begin
                    if (hit && miss < 255) miss++;
                    if (!enable) begin
                        on = 0; waiting = 0;
                    end else if (taps == 0) begin
                        waiting = 0;
                    end
                end else begin
                    if (!enable) on = 0;
                    else if (hit) begin
                        qc.push_back(cap);
                        qf.push_back($countones(taps));
                        holding = 1;
                    end
                end
            end
            prev = taps;
        end
    end

    // Monitor: per-cycle state checks plus scoreboard pop on handshake.
    always @(negedge clk) begin
        int ec;
        int ef;
        if (rst) begin
            chk("ts_valid", v16, holding);
            chk("ts_valid_w4", v4, holding);
            chk("busy", b16, holding || dead_left > 0 || waiting);
            chk("miss_cnt", m16, miss);
            chk("miss_cnt_w4", m4, miss);
            if (v16 && ts_ready) begin
                if (qc.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_ts: coarse %0d fine %0d, none expected",
                             c16, f16);
                end else begin
                    ec = qc.pop_front();
                    ef = qf.pop_front();
                    chk("ts_coarse", c16, ec);
                    chk("ts_fine", f16, ef);
                    chk("ts_coarse_w4", c4, ec % 16);
                    chk("ts_fine_w4", f4, ef);
                end
            end
        end
    end

    task automatic drive(input bit e, input logic [11:0] t, input bit r);
        enable = e;
        taps = t;
        ts_ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [11:0] t;
        bit e, r;
        #1;
        chk("rst_valid", v16, 0);
        chk("rst_busy", b16, 0);
        chk("rst_coarse", c16, 0);
        chk("rst_fine", f16, 0);
        chk("rst_miss", m16, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        drive(1, 12'h000, 0);
        repeat (5) drive(1, 12'h000, 0);
        drive(1, 12'h07F, 0);
        chk("basic_valid", v16, 1);
        chk("basic_coarse", c16, 16'h0005);
        chk("basic_fine", f16, 7);

        repeat (3) drive(1, 12'h07F, 0);
        repeat (3) drive(1, 12'h000, 0);
        repeat (4) drive(1, 12'h003, 0);
        chk("bp_miss", m16, 1);
        chk("bp_valid", v16, 1);
        chk("bp_coarse", c16, 16'h0005);
        chk("bp_fine", f16, 7);

        drive(1, 12'h000, 1);
        chk("dead_busy", b16, 1);
        drive(1, 12'hFFF, 0);
        chk("dead_miss", m16, 2);
        repeat (7) drive(1, 12'hFFF, 0);
        chk("rearm_busy", b16, 1);
        drive(1, 12'h000, 0);
        chk("armed_busy", b16, 0);

        drive(1, 12'h0FB, 0);
        chk("bubble_fine", f16, 7);
        drive(1, 12'h000, 1);
        repeat (6) drive(1, 12'h000, 0);
        drive(1, 12'hFFF, 0);
        chk("full_fine", f16, 12);
        chk("full_valid", v16, 1);

        rst = 1'b0;
        #1;
        chk("async_valid", v16, 0);
        chk("async_valid_w4", v4, 0);
        chk("async_miss", m16, 0);
        chk("async_busy", b16, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) drive(1, 12'hFFF, 0);
        chk("fresh_hit_valid", v16, 0);

        repeat (3000) begin
            e = ($urandom_range(0, 99) < 97);
            r = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) t = '0;
            else if ($urandom_range(0, 1) == 0) t = 12'hFFF >> $urandom_range(0, 11);
            else t = 12'($urandom_range(1, 4095));
            drive(e, t, r);
        end
        repeat (12) drive(1, 12'h000, 1);
        chk("drain_queue", qc.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
